// File: rtl/par_to_serial_tx.sv
// -----------------------------------------------------------------------------
// par_to_serial_tx
//
// Serializes bytes from the upstream 4:1 mux stage into a continuous MSB-first
// bit stream, one 8-bit symbol every 8 clocks with no gaps. After reset the
// block first sends ALIGN_COUNT COM symbols (IDLE_SYM) so the receiver can find
// symbol boundaries. After that it sends buffered data bytes, or COM whenever
// no byte is waiting.
//
// Parameters
//   IDLE_SYM     COM symbol used for alignment and idle fill
//   ALIGN_COUNT  COM symbols sent after reset before data may flow (1..15)
//
// Ports
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   in         in   8  parallel data byte
//   valid_in   in   1  in carries a valid byte this cycle
//   ready_out  out  1  a byte offered this cycle is taken (NOT hold_valid)
//   data_out   out  1  registered serial bit, MSB first
//   sym_start  out  1  registered; data_out carries bit 7 of a symbol
//   data_sym   out  1  registered; current symbol is a data byte (0 = COM)
//   aligned    out  1  registered; alignment finished, FSM is in RUN
// -----------------------------------------------------------------------------
module par_to_serial_tx #(
  parameter logic [7:0]  IDLE_SYM    = 8'hBC,
  parameter int unsigned ALIGN_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sym_start,
  output logic       data_sym,
  output logic       aligned
);

  // Value of align_cnt when the last alignment COM is being loaded.
  localparam logic [3:0] ALIGN_LAST = 4'(ALIGN_COUNT - 1);

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e     state_q,      state_d;
  logic [3:0] align_cnt_q,  align_cnt_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic [7:0] sreg_q,       sreg_d;
  logic [7:0] hold_q,       hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       data_out_q,   data_out_d;
  logic       sym_start_q,  sym_start_d;
  logic       data_sym_q,   data_sym_d;
  logic       aligned_q,    aligned_d;

  logic       load_slot_s;
  logic       accept_s;
  logic [7:0] sym_s;

  // Next-state logic: symbol selection at load slots, shifting between them,
  // and the one-byte input handshake.
  always_comb begin
    state_d      = state_q;
    align_cnt_d  = align_cnt_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;   // wraps 7 -> 0: one symbol per 8 clocks
    sreg_d       = sreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    data_out_d   = data_out_q;
    sym_start_d  = 1'b0;
    data_sym_d   = data_sym_q;
    sym_s        = IDLE_SYM;

    load_slot_s  = (bit_cnt_q == 3'd0);
    // A byte can only be taken while the holding register is empty, so an
    // accept never collides with hold being consumed on the same edge.
    accept_s     = valid_in & ~hold_valid_q;

    if (load_slot_s) begin
      case (state_q)
        ST_ALIGN: begin
          // Alignment never touches hold; a byte taken here waits for RUN.
          sym_s       = IDLE_SYM;
          data_sym_d  = 1'b0;
          align_cnt_d = align_cnt_q + 4'd1;
          if (align_cnt_q == ALIGN_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ALIGN;
          end
        end
        ST_RUN: begin
          if (hold_valid_q) begin
            sym_s        = hold_q;
            data_sym_d   = 1'b1;
            hold_valid_d = 1'b0;
          end else begin
            sym_s        = IDLE_SYM;
            data_sym_d   = 1'b0;
          end
        end
        default: begin
          state_d    = ST_ALIGN;
          sym_s      = IDLE_SYM;
          data_sym_d = 1'b0;
        end
      endcase
      data_out_d  = sym_s[7];
      sreg_d      = {sym_s[6:0], 1'b0};
      sym_start_d = 1'b1;
    end else begin
      data_out_d  = sreg_q[7];
      sreg_d      = {sreg_q[6:0], 1'b0};
      sym_start_d = 1'b0;
    end

    if (accept_s) begin
      hold_d       = in;
      hold_valid_d = 1'b1;
    end else begin
      hold_d       = hold_q;
    end

    // aligned is registered alongside the state so it rises on the very edge
    // that enters RUN.
    aligned_d = (state_d == ST_RUN);
  end

  // State register with synchronous reset; reset restarts alignment and drops
  // any partial symbol and buffered byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ALIGN;
      align_cnt_q  <= 4'd0;
      bit_cnt_q    <= 3'd0;
      sreg_q       <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      data_out_q   <= 1'b0;
      sym_start_q  <= 1'b0;
      data_sym_q   <= 1'b0;
      aligned_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      align_cnt_q  <= align_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      data_out_q   <= data_out_d;
      sym_start_q  <= sym_start_d;
      data_sym_q   <= data_sym_d;
      aligned_q    <= aligned_d;
    end
  end

  assign ready_out = ~hold_valid_q;
  assign data_out  = data_out_q;
  assign sym_start = sym_start_q;
  assign data_sym  = data_sym_q;
  assign aligned   = aligned_q;

endmodule

// File: tb/tb_par_to_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_par_to_serial_tx
//
// Self-checking bench for par_to_serial_tx. A symbol-level reference model
// (current symbol byte + bit position + one-entry buffer) predicts every
// output after every clock. Directed tables and sequences cover the reset,
// alignment, latency, back-to-back and reset-abandon cases. A second instance
// with ALIGN_COUNT=1 covers the shortest alignment.
// -----------------------------------------------------------------------------
module tb_par_to_serial_tx;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int         MA   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] in_b;
  logic       ready_out, data_out, sym_start, data_sym, aligned;
  logic       ready1, dout1, ss1, ds1, al1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  par_to_serial_tx #(.IDLE_SYM(IDLE), .ALIGN_COUNT(MA)) dut (
    .clk(clk), .reset(reset), .in(in_b), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .sym_start(sym_start),
    .data_sym(data_sym), .aligned(aligned)
  );

  par_to_serial_tx #(.IDLE_SYM(IDLE), .ALIGN_COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .in(in_b), .valid_in(valid_in),
    .ready_out(ready1), .data_out(dout1), .sym_start(ss1),
    .data_sym(ds1), .aligned(al1)
  );

  // Reference model: symbol-level view of the transmitter.
  int         m_edges;      // clock edges since reset was released
  int         m_syms;       // symbols started since reset was released
  logic [7:0] m_sym;        // symbol currently on the wire
  logic       m_data;       // current symbol is a data byte
  logic [7:0] m_hold;
  logic       m_hold_valid;
  logic       e_dout, e_ss, e_ds, e_al, e_rdy;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: sample inputs, advance model, compare all outputs after edge.
  task automatic step();
    logic r, v, rdy;
    logic [7:0] d;
    int ph;
    r = reset; v = valid_in; d = in_b;
    @(posedge clk);
    if (r) begin
      m_edges = 0; m_syms = 0; m_sym = 8'h00; m_data = 1'b0;
      m_hold = 8'h00; m_hold_valid = 1'b0;
      e_dout = 1'b0; e_ss = 1'b0; e_ds = 1'b0; e_al = 1'b0;
    end else begin
      rdy = !m_hold_valid;
      ph  = m_edges % 8;
      if (ph == 0) begin
        if (m_syms >= MA && m_hold_valid) begin
          m_sym = m_hold; m_data = 1'b1; m_hold_valid = 1'b0;
        end else begin
          m_sym = IDLE; m_data = 1'b0;
        end
        if (m_syms < 1000) m_syms++;
      end
      e_dout = m_sym[7 - ph];
      e_ss   = (ph == 0);
      e_ds   = m_data;
      e_al   = (m_syms >= MA);
      if (v && rdy) begin
        m_hold = d; m_hold_valid = 1'b1;
      end
      m_edges++;
    end
    e_rdy = !m_hold_valid;
    #1;
    chk("model{dout,ss,ds,al,rdy}",
        {27'd0, data_out, sym_start, data_sym, aligned, ready_out},
        {27'd0, e_dout, e_ss, e_ds, e_al, e_rdy});
  endtask

  // Offer n bytes with valid held, capture ncap bits starting at the first
  // data symbol start.
  task automatic send_capture(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int ncap,
                              output logic [63:0] bits, output logic [63:0] dsy);
    logic [7:0] bl [3];
    int idx, cnt, budget;
    logic cap, acc;
    bl[0] = b0; bl[1] = b1; bl[2] = b2;
    idx = 0; cnt = 0; cap = 1'b0; bits = 64'd0; dsy = 64'd0;
    valid_in = 1'b1; in_b = bl[0];
    for (budget = 0; budget < 200 && cnt < ncap; budget++) begin
      acc = valid_in & ready_out;
      step();
      if (acc) begin
        idx++;
        if (idx >= n) valid_in = 1'b0;
        else in_b = bl[idx];
      end
      if (!cap && data_sym && sym_start) cap = 1'b1;
      if (cap) begin
        bits = {bits[62:0], data_out};
        dsy  = {dsy[62:0], data_sym};
        cnt++;
      end
    end
    valid_in = 1'b0;
    chk("capture_complete", cnt, ncap);
  endtask

  typedef struct {
    int   k;
    logic dout, ss, ds, al, rdy;
  } vec_t;
  vec_t tbl [10];

  logic [63:0] bits, dsy;
  logic [31:0] serial;
  int          first_al, ss_cnt, ds_cnt, ti, budget;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // in=5A held with valid from reset release.
    tbl[0] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{25, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; valid_in = 1'b0; in_b = 8'h00;
    repeat (3) step();
    chk("reset_outputs", {27'd0, data_out, sym_start, data_sym, aligned, ready_out}, 32'h1);
    chk("reset_aligned_ac1", {31'd0, al1}, 32'd0);

    // Alignment with no traffic.
    reset = 1'b0;
    serial = 32'd0; first_al = -1; ss_cnt = 0; ds_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 1) begin
        chk("ac1_aligned_first_edge", {31'd0, al1}, 32'd1);
        chk("ac1_sym_start_first_edge", {31'd0, ss1}, 32'd1);
      end
      serial = {serial[30:0], data_out};
      if (sym_start) ss_cnt++;
      if (data_sym) ds_cnt++;
      if (aligned && first_al < 0) first_al = k;
    end
    chk("align_serial", serial, 32'hBCBCBCBC);
    chk("align_sym_start_count", ss_cnt, 4);
    chk("align_first_aligned_clk", first_al, 25);
    chk("align_no_data_sym", ds_cnt, 0);

    // Byte offered from reset release: table of checkpoints.
    reset = 1'b1; step();
    reset = 1'b0; valid_in = 1'b1; in_b = 8'h5A;
    ti = 0;
    for (int k = 1; k <= 41; k++) begin
      step();
      if (ti < 10 && tbl[ti].k == k) begin
        chk($sformatf("tbl_k%0d", k),
            {27'd0, data_out, sym_start, data_sym, aligned, ready_out},
            {27'd0, tbl[ti].dout, tbl[ti].ss, tbl[ti].ds, tbl[ti].al, tbl[ti].rdy});
        ti++;
      end
    end
    chk("tbl_all_applied", ti, 10);

    // Back-to-back bytes, then a single byte followed by idle COM.
    valid_in = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (32) step();
    send_capture(3, 8'hFF, 8'h00, 8'h81, 24, bits, dsy);
    chk("b2b_serial", bits[23:0], 24'hFF0081);
    chk("b2b_data_sym", dsy[23:0], 24'hFFFFFF);
    send_capture(1, 8'h3C, 8'h00, 8'h00, 24, bits, dsy);
    chk("single_serial", bits[23:0], 24'h3CBCBC);
    chk("single_data_sym", dsy[23:0], 24'hFF0000);

    // Reset in the middle of A5 with C3 buffered.
    valid_in = 1'b1; in_b = 8'hA5;
    for (budget = 0; budget < 100 && !(ready_out && valid_in && data_sym == 1'b0 && sym_start == 1'b0 && 1'b0); budget++) begin
      if (ready_out) break;
      step();
    end
    step();                             // A5 accepted on this edge
    in_b = 8'hC3;
    for (budget = 0; budget < 40; budget++) begin
      step();
      if (sym_start && data_sym) break;
    end
    chk("a5_loaded", {31'd0, sym_start & data_sym}, 32'd1);
    chk("a5_first_bit", {31'd0, data_out}, 32'd1);
    step();                             // C3 accepted, bit_cnt=2
    valid_in = 1'b0;
    step(); step();                     // bit_cnt=4
    chk("c3_in_hold", {31'd0, ready_out}, 32'd0);
    reset = 1'b1;
    step();
    chk("midsym_reset_outputs", {27'd0, data_out, sym_start, data_sym, aligned, ready_out}, 32'h1);
    reset = 1'b0;
    serial = 32'd0; ds_cnt = 0;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k <= 32) serial = {serial[30:0], data_out};
      if (data_sym) ds_cnt++;
    end
    chk("post_reset_com", serial, 32'hBCBCBCBC);
    chk("c3_never_sent", ds_cnt, 0);

    // Random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 399) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      in_b     = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
